// File: rtl/tdm_pkg.sv
`default_nettype none
// ============================================================================
// Package     : tdm_pkg
// Description : Shared definitions for the TDM mux/demux pair: FSM state
//               encoding and default frame geometry (channels, slot width).
// Revision    : 1.0 - initial release
// ============================================================================
package tdm_pkg;

  // Default number of time slots per frame and data width of one slot.
  localparam int TDM_CH = 4;
  localparam int TDM_W  = 8;

  // IDLE: hunting for a sync beat; RUN: collecting the slots of a frame.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage : tdm_pkg
`default_nettype wire

// File: rtl/tdm_slot_cnt.sv
`default_nettype none
// ============================================================================
// Module      : tdm_slot_cnt
// Description : Slot index counter for a TDM frame, with wrap and clear.
//   clk   in   clock, rising edge
//   rst_n in   asynchronous active-low reset
//   inc   in   count one accepted beat (wraps CH-1 -> 0)
//   clr   in   restart the frame; together with inc the restarting beat is
//              itself counted as slot 0, so the next index is 1
//   slot  out  index of the next expected slot
//   last  out  high while slot == CH-1
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_slot_cnt
  import tdm_pkg::*;
#(
  parameter int CH = TDM_CH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inc,
  input  logic                  clr,
  output logic [$clog2(CH)-1:0] slot,
  output logic                  last
);

  localparam int            SW       = $clog2(CH);
  localparam logic [SW-1:0] C_LAST   = SW'(CH - 1);

  logic [SW-1:0] slot_q;
  logic [SW-1:0] slot_d;

  always_comb begin
    slot_d = slot_q;
    if (clr && inc) begin
      slot_d = SW'(1);
    end else if (clr) begin
      slot_d = '0;
    end else if (inc) begin
      slot_d = (slot_q == C_LAST) ? '0 : slot_q + SW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign slot = slot_q;
  assign last = (slot_q == C_LAST);

endmodule : tdm_slot_cnt
`default_nettype wire

// File: rtl/tdm_demux_e.sv
`default_nettype none
// ============================================================================
// Module      : tdm_demux_e
// Description : TDM demultiplexer with enable. Collects CH slots of W bits
//               into a shadow frame and publishes complete frames only.
//   clk         in   clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   din         in   time-multiplexed data beat
//   sync        in   frame marker, high on the slot-0 beat
//   e           in   beat enable
//   ch_data     out  last complete frame, slot k at [k*W +: W]
//   frame_valid out  one-cycle pulse when ch_data was just updated
//   sync_err    out  one-cycle pulse on early or missing sync
//   slot        out  index of the next expected slot
// Revision    : 1.0 - initial release
// ============================================================================
module tdm_demux_e
  import tdm_pkg::*;
#(
  parameter int CH = TDM_CH,
  parameter int W  = TDM_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [W-1:0]          din,
  input  logic                  sync,
  input  logic                  e,
  output logic [CH*W-1:0]       ch_data,
  output logic                  frame_valid,
  output logic                  sync_err,
  output logic [$clog2(CH)-1:0] slot
);

  localparam int SW = $clog2(CH);

  state_e                state_q;
  logic [CH-1:0][W-1:0]  shadow_q;
  logic [CH-1:0][W-1:0]  ch_data_q;
  logic [CH-1:0][W-1:0]  frame_d;
  logic                  frame_valid_q;
  logic                  sync_err_q;

  logic                  accept;
  logic                  cnt_inc;
  logic                  cnt_clr;
  logic [SW-1:0]         cnt_slot;
  logic                  cnt_last;
  logic                  at_slot0;

  // (sync | ~sync) is 1 for a known sync and X otherwise, so an unknown
  // e or sync leaves accept non-true and the beat is not taken.
  assign accept   = e & (sync | ~sync);
  assign at_slot0 = (cnt_slot == '0);

  // Any sync beat restarts the count at 1; a non-sync beat while hunting or
  // at slot 0 (missing sync) parks the counter at 0.
  assign cnt_clr = accept & (sync | (state_q == IDLE) | at_slot0);
  assign cnt_inc = accept & (sync | ((state_q == RUN) & ~at_slot0));

  tdm_slot_cnt #(
    .CH (CH)
  ) u_slot_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (cnt_inc),
    .clr   (cnt_clr),
    .slot  (cnt_slot),
    .last  (cnt_last)
  );

  // The final beat is merged in on the same edge it is accepted.
  always_comb begin
    frame_d          = shadow_q;
    frame_d[CH-1]    = din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      shadow_q      <= '0;
      ch_data_q     <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
    end else begin
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (accept) begin
        case (state_q)
          IDLE: begin
            if (sync) begin
              shadow_q[0] <= din;
              state_q     <= RUN;
            end
          end
          RUN: begin
            if (sync) begin
              // Sync at slot 0 continues back-to-back; anywhere else it is
              // early and the partial frame is abandoned.
              shadow_q[0] <= din;
              if (!at_slot0) begin
                sync_err_q <= 1'b1;
              end
            end else if (at_slot0) begin
              sync_err_q <= 1'b1;
              state_q    <= IDLE;
            end else begin
              shadow_q[cnt_slot] <= din;
              if (cnt_last) begin
                ch_data_q     <= frame_d;
                frame_valid_q <= 1'b1;
              end
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign ch_data     = ch_data_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign slot        = cnt_slot;

  a_ctrl_known : assert property (
    @(posedge clk) disable iff (!rst_n)
      !$isunknown(e) && (!e || !$isunknown(sync))
  );

endmodule : tdm_demux_e
`default_nettype wire

// File: tb/tb_tdm_demux_e.sv
`default_nettype none
// ============================================================================
// Module      : tb_tdm_demux_e
// Description : Directed self-checking bench for tdm_demux_e (CH=4, W=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tdm_demux_e;

  localparam int CH = 4;
  localparam int W  = 8;

  logic            clk;
  logic            rst_n;
  logic [W-1:0]    din;
  logic            sync;
  logic            e;
  logic [CH*W-1:0] ch_data;
  logic            frame_valid;
  logic            sync_err;
  logic [1:0]      slot;

  int n_cmp  = 0;
  int n_fail = 0;

  tdm_demux_e #(
    .CH (CH),
    .W  (W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .din         (din),
    .sync        (sync),
    .e           (e),
    .ch_data     (ch_data),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .slot        (slot)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // Present one beat, clock it in, and return 1 ns after the edge.
  task automatic beat(input logic [7:0] d, input logic s, input logic en);
    din  = d;
    sync = s;
    e    = en;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_flags(input string tag, input logic fv, input logic err);
    check({tag, ".fv"},  {31'd0, frame_valid}, {31'd0, fv});
    check({tag, ".err"}, {31'd0, sync_err},    {31'd0, err});
  endtask

  initial begin
    rst_n = 1'b0;
    din   = '0;
    sync  = 1'b0;
    e     = 1'b0;
    #2;
    check("rst.ch_data", ch_data, 32'h0);
    chk_flags("rst", 1'b0, 1'b0);
    check("rst.slot", {30'd0, slot}, 32'd0);
    #6 rst_n = 1'b1;

    // Non-sync beat while hunting is discarded silently.
    beat(8'h55, 1'b0, 1'b1);
    check("idle_discard.slot", {30'd0, slot}, 32'd0);
    chk_flags("idle_discard", 1'b0, 1'b0);

    // Clean frame.
    beat(8'hA0, 1'b1, 1'b1);
    check("clean.slot1", {30'd0, slot}, 32'd1);
    beat(8'hB1, 1'b0, 1'b1);
    beat(8'hC2, 1'b0, 1'b1);
    check("clean.partial_hidden", ch_data, 32'h0);
    chk_flags("clean.pre", 1'b0, 1'b0);
    beat(8'hD3, 1'b0, 1'b1);
    check("clean.ch_data", ch_data, 32'hD3C2B1A0);
    chk_flags("clean.done", 1'b1, 1'b0);
    check("clean.slot_wrap", {30'd0, slot}, 32'd0);
    beat(8'h00, 1'b0, 1'b0);
    chk_flags("clean.after", 1'b0, 1'b0);

    // Stall: garbage with sync=1 while e=0 must be ignored.
    beat(8'h10, 1'b1, 1'b1);
    beat(8'h21, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      beat(8'hFF, 1'b1, 1'b0);
      chk_flags("stall.hold", 1'b0, 1'b0);
      check("stall.slot", {30'd0, slot}, 32'd2);
    end
    beat(8'h32, 1'b0, 1'b1);
    check("stall.ch_data_old", ch_data, 32'hD3C2B1A0);
    beat(8'h43, 1'b0, 1'b1);
    check("stall.ch_data", ch_data, 32'h43322110);
    chk_flags("stall.done", 1'b1, 1'b0);

    // Early sync.
    beat(8'h11, 1'b1, 1'b1);
    beat(8'h22, 1'b0, 1'b1);
    beat(8'h33, 1'b1, 1'b1);
    chk_flags("early.err", 1'b0, 1'b1);
    check("early.slot", {30'd0, slot}, 32'd1);
    beat(8'h44, 1'b0, 1'b1);
    chk_flags("early.err_clr", 1'b0, 1'b0);
    beat(8'h55, 1'b0, 1'b1);
    beat(8'h66, 1'b0, 1'b1);
    check("early.ch_data", ch_data, 32'h66554433);
    chk_flags("early.done", 1'b1, 1'b0);

    // Missing sync after a full frame.
    beat(8'h77, 1'b0, 1'b1);
    chk_flags("miss.err", 1'b0, 1'b1);
    check("miss.ch_data", ch_data, 32'h66554433);
    beat(8'h88, 1'b0, 1'b1);
    beat(8'h99, 1'b0, 1'b1);
    chk_flags("miss.ignored", 1'b0, 1'b0);
    check("miss.slot", {30'd0, slot}, 32'd0);
    check("miss.ch_keep", ch_data, 32'h66554433);

    // Back-to-back frames.
    for (int i = 0; i < 8; i++) begin
      beat(8'hA0 + 8'(i), (i % 4) == 0, 1'b1);
      chk_flags("b2b", (i % 4) == 3, 1'b0);
      if (i == 3) check("b2b.frame0", ch_data, 32'hA3A2A1A0);
      if (i == 7) check("b2b.frame1", ch_data, 32'hA7A6A5A4);
    end

    // Sync on the last slot: error wins, no frame published.
    beat(8'hE0, 1'b1, 1'b1);
    beat(8'hE1, 1'b0, 1'b1);
    beat(8'hE2, 1'b0, 1'b1);
    beat(8'hE3, 1'b1, 1'b1);
    chk_flags("last_sync", 1'b0, 1'b1);
    check("last_sync.ch_data", ch_data, 32'hA7A6A5A4);
    beat(8'hF1, 1'b0, 1'b1);
    beat(8'hF2, 1'b0, 1'b1);
    beat(8'hF3, 1'b0, 1'b1);
    check("last_sync.resume", ch_data, 32'hF3F2F1E3);
    chk_flags("last_sync.resume", 1'b1, 1'b0);

    // Asynchronous reset mid-frame, between clock edges.
    beat(8'hC0, 1'b1, 1'b1);
    beat(8'hC1, 1'b0, 1'b1);
    beat(8'hC2, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("areset.ch_data", ch_data, 32'h0);
    check("areset.slot", {30'd0, slot}, 32'd0);
    chk_flags("areset", 1'b0, 1'b0);
    e = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    beat(8'h5A, 1'b0, 1'b1);
    check("areset.hunt", {30'd0, slot}, 32'd0);
    beat(8'hA0, 1'b1, 1'b1);
    beat(8'hB1, 1'b0, 1'b1);
    beat(8'hC2, 1'b0, 1'b1);
    beat(8'hD3, 1'b0, 1'b1);
    check("areset.frame", ch_data, 32'hD3C2B1A0);
    chk_flags("areset.frame", 1'b1, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_tdm_demux_e
`default_nettype wire
